// File: rtl/cnt_ctrl_if.sv
// Bundles the button inputs, counter TC and the control outputs of cnt_ctrl.
// Latency: none, wires only.
// Backpressure: none; the counter side always accepts ce/s pulses.
// Ports: btn_run/btn_step/btn_set raw buttons, tc_in counter terminal count,
//        ce clock-enable, s preset, tick prescaler pulse, running RUN status.
interface cnt_ctrl_if;
    logic btn_run;
    logic btn_step;
    logic btn_set;
    logic tc_in;
    logic ce;
    logic s;
    logic tick;
    logic running;

    // master: the control block that drives ce/s to the counter
    modport master (
        input  btn_run, btn_step, btn_set, tc_in,
        output ce, s, tick, running
    );

    // slave: the counter / button environment around the control block
    modport slave (
        output btn_run, btn_step, btn_set, tc_in,
        input  ce, s, tick, running
    );
endinterface

// File: rtl/cnt_ctrl.sv
// Button front-end for a down-counter: prescaler, debounce, run/step/preset FSM.
// Latency: raw edge -> press = 2 clk + DB_TICKS stable ticks; press -> ce/s = 1 clk.
// Backpressure: none; ce and s are single-cycle pulses the counter must take.
// Ports: clk, rst_n (async, active low), bus (cnt_ctrl_if.master).
module cnt_ctrl #(
    parameter int TICK_DIV  = 50000,
    parameter int DIV_W     = 16,
    parameter int DB_TICKS  = 4,
    parameter int AUTO_STOP = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    cnt_ctrl_if.master   bus
);

    localparam int              CW       = $clog2(DB_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CW-1:0]    DB_LAST  = CW'(DB_TICKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

    logic [DIV_W-1:0]    div_cnt;
    logic                tick_q;
    logic [2:0]          raw;
    logic [2:0]          sync1;
    logic [2:0]          sync2;
    logic [2:0]          db;
    logic [2:0]          db_q;
    logic [2:0][CW-1:0]  stab;
    logic [2:0]          press;
    logic                run_press;
    logic                step_press;
    logic                set_press;
    state_t              state;
    state_t              state_nxt;
    logic                ce_q;
    logic                ce_nxt;
    logic                s_q;
    logic                s_nxt;

    // bit 0 run, bit 1 step, bit 2 set
    assign raw = {bus.btn_set, bus.btn_step, bus.btn_run};

    // prescaler; tick is registered so it lands one cycle after the wrap value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= (div_cnt == DIV_LAST);
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // two-flop synchronizers, then per-button debounce sampled only on tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            stab  <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_q  <= db;
            if (tick_q) begin
                for (int i = 0; i < 3; i++) begin
                    if (sync2[i] == db[i]) begin
                        stab[i] <= '0;
                    end else if (stab[i] == DB_LAST) begin
                        // this tick is the DB_TICKS-th differing sample
                        db[i]   <= sync2[i];
                        stab[i] <= '0;
                    end else begin
                        stab[i] <= stab[i] + CW'(1);
                    end
                end
            end
        end
    end

    // rising edge of the debounced level only; release is silent
    assign press      = db & ~db_q;
    assign run_press  = press[0];
    assign step_press = press[1];
    assign set_press  = press[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ce_q  <= 1'b0;
            s_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            ce_q  <= ce_nxt;
            s_q   <= s_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ce_nxt    = 1'b0;
        s_nxt     = set_press;
        case (state)
            IDLE: begin
                if (run_press) begin
                    state_nxt = RUN;
                end else if (step_press) begin
                    // ce is issued while sitting in STEP, one cycle after the press
                    state_nxt = STEP;
                    ce_nxt    = 1'b1;
                end
            end
            RUN: begin
                if (run_press) begin
                    state_nxt = IDLE;
                end else if (tick_q) begin
                    if ((AUTO_STOP != 0) && bus.tc_in) begin
                        state_nxt = IDLE;
                    end else begin
                        ce_nxt = 1'b1;
                    end
                end
            end
            STEP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // a preset cycle never carries a count enable
        if (set_press) begin
            ce_nxt = 1'b0;
        end
    end

    assign bus.ce      = ce_q;
    assign bus.s       = s_q;
    assign bus.tick    = tick_q;
    assign bus.running = (state == RUN);

endmodule
